// File: rtl/credit_icon_ctrl.sv
// rtl/credit_icon_ctrl.sv - coin/credit controller with credit-icon HUD renderer
module credit_icon_ctrl #(
  parameter int         MAX_CREDITS      = 5,
  parameter int         COINS_PER_CREDIT = 1,
  parameter int         DEBOUNCE_CYCLES  = 16,
  parameter int         ICON_PITCH_LOG2  = 4,
  parameter int         BLINK_FRAMES     = 16,
  parameter logic [7:0] TRANSPARENT      = 8'h00
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        coinN,
  input  logic        startReq,
  input  logic        freePlay,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [3:0]  credits,
  output logic [2:0]  coinCount,
  output logic        gameGrant
);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  deb_state_t     deb_state, deb_state_next;
  logic [CW-1:0]  deb_cnt, deb_cnt_next;
  logic           coin_s1, coin_s2;
  logic           coin_accept;
  logic           start_d1, start_edge, grant_ok;
  logic           credit_inc, credit_dec;
  logic [4:0]     credit_sum;
  logic [3:0]     credits_next;
  logic [5:0]     blink_cnt;
  logic [10:0]    icon_idx, lx_full;
  logic           icon_hidden, eligible;

  // Sync flops preset high so a key held through reset release still debounces.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coin_s1 <= 1'b1;
      coin_s2 <= 1'b1;
    end else begin
      coin_s1 <= coinN;
      coin_s2 <= coin_s1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      deb_state <= RELEASED;
      deb_cnt   <= '0;
    end else begin
      deb_state <= deb_state_next;
      deb_cnt   <= deb_cnt_next;
    end
  end

  always_comb begin
    deb_state_next = deb_state;
    deb_cnt_next   = deb_cnt;
    coin_accept    = 1'b0;
    case (deb_state)
      RELEASED: if (!coin_s2) begin
        deb_state_next = PRESS_WAIT;
        deb_cnt_next   = CW'(1);
      end
      PRESS_WAIT: begin
        if (coin_s2) deb_state_next = RELEASED;
        else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_state_next = PRESSED;
          coin_accept    = 1'b1;
        end else deb_cnt_next = deb_cnt + CW'(1);
      end
      PRESSED: if (coin_s2) begin
        deb_state_next = RELEASE_WAIT;
        deb_cnt_next   = CW'(1);
      end
      RELEASE_WAIT: begin
        if (!coin_s2) deb_state_next = PRESSED;
        else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) deb_state_next = RELEASED;
        else deb_cnt_next = deb_cnt + CW'(1);
      end
      default: deb_state_next = RELEASED;
    endcase
  end

  assign credit_inc = coin_accept && (coinCount == 3'(COINS_PER_CREDIT - 1));
  assign start_edge = startReq && !start_d1;
  assign grant_ok   = start_edge && (freePlay || credits != 4'd0);
  assign credit_dec = grant_ok && !freePlay;

  // Single adder; dec only happens with credits >= 1, so no underflow.
  assign credit_sum   = {1'b0, credits} + 5'(credit_inc) - 5'(credit_dec);
  assign credits_next = (credit_sum > 5'(MAX_CREDITS)) ? 4'(MAX_CREDITS) : credit_sum[3:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coinCount <= '0;
      credits   <= '0;
      start_d1  <= 1'b0;
      gameGrant <= 1'b0;
      blink_cnt <= '0;
    end else begin
      if (credit_inc)       coinCount <= '0;
      else if (coin_accept) coinCount <= coinCount + 3'd1;
      start_d1  <= startReq;
      gameGrant <= grant_ok;
      credits   <= credits_next;
      if (credits_next != credits)              blink_cnt <= 6'(BLINK_FRAMES);
      else if (startOfFrame && blink_cnt != '0) blink_cnt <= blink_cnt - 6'd1;
    end
  end

  function automatic logic [7:0] coin_rom(input logic [3:0] y, input logic [3:0] x);
    int dx, dy, r2;
    dx = 2 * int'(x) - 15;
    dy = 2 * int'(y) - 15;
    r2 = dx * dx + dy * dy;
    if (r2 > 225)      coin_rom = TRANSPARENT;
    else if (r2 > 144) coin_rom = 8'hC4;
    else if (x >= 4'd7 && x <= 4'd8 && y >= 4'd4 && y <= 4'd11) coin_rom = 8'hF8;
    else               coin_rom = 8'hFC;
  endfunction

  assign icon_idx    = offsetX >> ICON_PITCH_LOG2;
  assign lx_full     = offsetX & 11'((1 << ICON_PITCH_LOG2) - 1);
  assign icon_hidden = blink_cnt[1] && (credits != 4'd0) && (icon_idx == 11'(credits) - 11'd1);
  assign eligible    = InsideRectangle && (offsetY < 11'd16) && (lx_full < 11'd16)
                       && (icon_idx < 11'(credits)) && !icon_hidden;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) RGBout <= TRANSPARENT;
    else         RGBout <= eligible ? coin_rom(offsetY[3:0], lx_full[3:0]) : TRANSPARENT;
  end

  assign drawingRequest = (RGBout != TRANSPARENT);

endmodule
